// File: rtl/timer_ctrl_if.sv
// Control/status bundle for timer_ctrl.
// Optional prescale field: TIMER_CTRL_PRESCALE_EN.
interface timer_ctrl_if #(
  parameter int WIDTH = 8
`ifdef TIMER_CTRL_PRESCALE_EN
  , parameter int PRE_W = 4
`endif
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tick;
  logic             done;
`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] prescale;

  modport master (
    output start, stop, clear, mode,
    output period, prescale,
    input  count, busy, tick, done
  );

  modport slave (
    input  start, stop, clear, mode,
    input  period, prescale,
    output count, busy, tick, done
  );
`else
  modport master (
    output start, stop, clear, mode, period,
    input  count, busy, tick, done
  );

  modport slave (
    input  start, stop, clear, mode, period,
    output count, busy, tick, done
  );
`endif
endinterface

// File: rtl/timer_ctrl.sv
// Start/pause/resume/abort controller around an up-counter.
// Optional prescaler: define TIMER_CTRL_PRESCALE_EN.
module timer_ctrl #(
  parameter int WIDTH = 8
`ifdef TIMER_CTRL_PRESCALE_EN
  , parameter int PRE_W = 4
`endif
) (
  input logic         clk,
  input logic         res,
  timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;
  logic             step;

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_s;

  assign step = (pre_q == pre_s);
`else
  assign step = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      period_q  <= '0;
      mode_q    <= 1'b0;
      bus.count <= '0;
      bus.busy  <= 1'b0;
      bus.tick  <= 1'b0;
      bus.done  <= 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
      pre_q     <= '0;
      pre_s     <= '0;
`endif
    end else begin
      bus.tick <= 1'b0;
      if (bus.clear) begin
        state     <= IDLE;
        bus.count <= '0;
        bus.busy  <= 1'b0;
        bus.done  <= 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
        pre_q     <= '0;
`endif
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              state     <= RUN;
              period_q  <= bus.period;
              mode_q    <= bus.mode;
              bus.count <= '0;
              bus.busy  <= 1'b1;
              bus.done  <= 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
              pre_q     <= '0;
              pre_s     <= bus.prescale;
`endif
            end
          end
          RUN: begin
            if (bus.stop) begin
              state <= PAUSE;
            end else begin
`ifdef TIMER_CTRL_PRESCALE_EN
              pre_q <= step ? '0 : pre_q + 1'b1;
`endif
              // terminal count: wrap and pulse
              if (step && bus.count == period_q) begin
                bus.count <= '0;
                bus.tick  <= 1'b1;
                if (!mode_q) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                end
              end else if (step) begin
                bus.count <= bus.count + 1'b1;
              end
            end
          end
          PAUSE: begin
            if (bus.start && !bus.stop) begin
              state <= RUN;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed table plus multi-cycle sequences for timer_ctrl.
// Prescaler cases build only with TIMER_CTRL_PRESCALE_EN.
module tb_timer_ctrl;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

`ifdef TIMER_CTRL_PRESCALE_EN
  timer_ctrl_if #(.WIDTH(8), .PRE_W(4)) bus ();
  timer_ctrl #(.WIDTH(8), .PRE_W(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );
`else
  timer_ctrl_if #(.WIDTH(8)) bus ();
  timer_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );
`endif

  typedef struct {
    string      name;
    logic       r;
    logic       s;
    logic       p;
    logic       c;
    logic       m;
    logic [7:0] per;
    logic [7:0] cnt;
    logic       b;
    logic       t;
    logic       d;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic r, s, p, c, m,
                     input logic [7:0] per, input logic [7:0] cnt,
                     input logic b, t, d);
    vec_t v;
    v.name = nm; v.r = r; v.s = s; v.p = p; v.c = c; v.m = m;
    v.per = per; v.cnt = cnt; v.b = b; v.t = t; v.d = d;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drv(input logic s, p, c, m, input logic [7:0] per);
    res        = 1'b0;
    bus.start  = s;
    bus.stop   = p;
    bus.clear  = c;
    bus.mode   = m;
    bus.period = per;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [7:0] cnt,
                         input logic b, t, d);
    chk({nm, ".count"}, 32'(bus.count), 32'(cnt));
    chk({nm, ".busy"},  32'(bus.busy),  32'(b));
    chk({nm, ".tick"},  32'(bus.tick),  32'(t));
    chk({nm, ".done"},  32'(bus.done),  32'(d));
  endtask

  initial begin
    drv(0, 0, 0, 0, 8'd0);
    res = 1'b1;
`ifdef TIMER_CTRL_PRESCALE_EN
    bus.prescale = '0;
`endif

    //  name       r s p c m per  cnt b t d
    add("reset",   1,0,0,0,0, 0,   0, 0,0,0);
    add("os_go",   0,1,0,0,0, 3,   0, 1,0,0);
    add("os_1",    0,0,0,0,0, 9,   1, 1,0,0);
    add("os_2",    0,0,0,0,0, 9,   2, 1,0,0);
    add("os_3",    0,0,0,0,0, 9,   3, 1,0,0);
    add("os_tick", 0,0,0,0,0, 9,   0, 0,1,1);
    add("os_hold", 0,0,0,0,0, 9,   0, 0,0,1);
    add("os_stop", 0,0,1,0,0, 9,   0, 0,0,1);
    add("pr_go",   0,1,0,0,1, 1,   0, 1,0,0);
    add("pr_1",    0,0,0,0,0, 5,   1, 1,0,0);
    add("pr_t1",   0,0,0,0,0, 5,   0, 1,1,0);
    add("pr_st",   0,1,0,0,0, 5,   1, 1,0,0);
    add("pr_t2",   0,1,0,0,0, 5,   0, 1,1,0);
    add("pz_stop", 0,0,1,0,0, 5,   0, 1,0,0);
    add("pz_both", 0,1,1,0,0, 5,   0, 1,0,0);
    add("pz_res",  0,1,0,0,0, 5,   0, 1,0,0);
    add("pz_run",  0,0,0,0,0, 5,   1, 1,0,0);
    add("clr_tc",  0,0,0,1,0, 5,   0, 0,0,0);
    add("p0_go",   0,1,0,0,1, 0,   0, 1,0,0);
    add("p0_t1",   0,0,0,0,0, 0,   0, 1,1,0);
    add("p0_t2",   0,0,0,0,0, 0,   0, 1,1,0);
    add("clr_st",  0,1,0,1,0, 0,   0, 0,0,0);
    add("os0_go",  0,1,0,0,0, 0,   0, 1,0,0);
    add("os0_t",   0,0,0,0,0, 0,   0, 0,1,1);
    add("clr_dn",  0,0,0,1,0, 0,   0, 0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      drv(vq[i].s, vq[i].p, vq[i].c, vq[i].m, vq[i].per);
      res = vq[i].r;
      cyc();
      chk_all(vq[i].name, vq[i].cnt, vq[i].b, vq[i].t, vq[i].d);
    end

    // periodic P=4: tick every fifth edge
    drv(1, 0, 0, 1, 8'd4);
    cyc();
    drv(0, 0, 0, 0, 8'd4);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("p4.count", 32'(bus.count), 32'(k % 5));
      chk("p4.tick", 32'(bus.tick), 32'((k % 5) == 0));
    end

    // full-range wrap
    drv(0, 0, 1, 0, 8'd0);
    cyc();
    drv(1, 0, 0, 1, 8'd255);
    cyc();
    drv(0, 0, 0, 0, 8'd255);
    repeat (255) cyc();
    chk_all("w255_top", 8'd255, 1, 0, 0);
    cyc();
    chk_all("w255_wrap", 8'd0, 1, 1, 0);

    // pause at 5 for 3 cycles, stop+start stays paused, then resume
    drv(0, 0, 1, 0, 8'd0);
    cyc();
    drv(1, 0, 0, 0, 8'd9);
    cyc();
    drv(0, 0, 0, 0, 8'd9);
    repeat (5) cyc();
    chk("pz9.pre", 32'(bus.count), 32'd5);
    drv(0, 1, 0, 0, 8'd9);
    repeat (3) begin
      cyc();
      chk_all("pz9.hold", 8'd5, 1, 0, 0);
    end
    drv(1, 1, 0, 0, 8'd9);
    cyc();
    chk_all("pz9.both", 8'd5, 1, 0, 0);
    drv(1, 0, 0, 0, 8'd9);
    cyc();
    chk_all("pz9.resume", 8'd5, 1, 0, 0);
    drv(0, 0, 0, 0, 8'd0);
    for (int k = 6; k <= 9; k++) begin
      cyc();
      chk_all("pz9.run", 8'(k), 1, 0, 0);
    end
    cyc();
    chk_all("pz9.tick", 8'd0, 0, 1, 1);

    // period input changes mid-run are ignored
    drv(1, 0, 0, 1, 8'd2);
    cyc();
    drv(0, 0, 0, 0, 8'd7);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk("chg.tick", 32'(bus.tick), 32'((k % 3) == 0));
    end

    // reset mid-run held two cycles
    drv(0, 0, 1, 0, 8'd0);
    cyc();
    drv(1, 0, 0, 1, 8'd5);
    cyc();
    drv(0, 0, 0, 0, 8'd5);
    repeat (3) cyc();
    chk("rst.pre", 32'(bus.count), 32'd3);
    res = 1'b1;
    cyc();
    chk_all("rst.1", 8'd0, 0, 0, 0);
    cyc();
    chk_all("rst.2", 8'd0, 0, 0, 0);
    res = 1'b0;
    repeat (6) cyc();
    chk_all("rst.after", 8'd0, 0, 0, 0);

`ifdef TIMER_CTRL_PRESCALE_EN
    // P=2, S=3: count steps every 4 edges, tick on edge 12
    bus.prescale = 4'd3;
    drv(1, 0, 0, 0, 8'd2);
    cyc();
    bus.prescale = 4'd0;
    drv(0, 0, 0, 0, 8'd2);
    for (int k = 1; k <= 11; k++) begin
      cyc();
      chk("ps.count", 32'(bus.count), 32'(k / 4));
      chk("ps.tick", 32'(bus.tick), 32'd0);
    end
    cyc();
    chk_all("ps.tick12", 8'd0, 0, 1, 1);

    // pause keeps prescaler phase
    bus.prescale = 4'd3;
    drv(1, 0, 0, 1, 8'd2);
    cyc();
    drv(0, 0, 0, 0, 8'd2);
    repeat (2) cyc();
    drv(0, 1, 0, 0, 8'd2);
    repeat (2) cyc();
    drv(1, 0, 0, 0, 8'd2);
    cyc();
    drv(0, 0, 0, 0, 8'd2);
    cyc();
    chk("psz.a", 32'(bus.count), 32'd0);
    cyc();
    chk("psz.b", 32'(bus.count), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
